sram_boot_loader: RTL

SRAM_BOOT_LOADER -- requirements
Module: sram_boot_loader

---
 rtl/sram_boot_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_boot_loader.sv
// sram_boot_loader
// Streams a byte-wide boot image into two four-lane SRAMs (imem, then dmem)
// and holds the core in reset until the last byte has been written.
// Each memory lane is one byte of a little-endian 32-bit word; byte n of a
// memory's image lands in lane n%4 at word address n/4. Writes are registered,
// so every accepted byte reaches its SRAM lane one cycle after acceptance.
module sram_boot_loader #(
    parameter int WORDS = 512
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    output logic [0:3]      CEN_imem,
    output logic [0:3]      GWEN_imem,
    output logic [0:3][7:0] WEN_imem,
    output logic [0:3][8:0] A_imem,
    output logic [0:3][7:0] D_imem,
    output logic [0:3]      CEN_dmem,
    output logic [0:3]      GWEN_dmem,
    output logic [0:3][7:0] WEN_dmem,
    output logic [0:3][8:0] A_dmem,
    output logic [0:3][7:0] D_dmem,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic [7:0]      checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_IMEM,
        LOAD_DMEM,
        DONE
    } state_e;

    localparam logic [8:0] LastAddr = 9'(WORDS - 1);

    state_e     state_q, state_d;
    logic [1:0] laneIdx_q, laneIdx_d;
    logic [8:0] wordAddr_q, wordAddr_d;
    logic [7:0] checksum_q, checksum_d;

    // Pending write: captured on the accepting edge, presented to the SRAM
    // pins during the following cycle.
    logic       wrValid_q, wrValid_d;
    logic       wrDmem_q, wrDmem_d;
    logic [1:0] wrLane_q, wrLane_d;
    logic [8:0] wrAddr_q, wrAddr_d;
    logic [7:0] wrData_q, wrData_d;

    logic loading;
    logic accept;

    assign loading  = (state_q == LOAD_IMEM) || (state_q == LOAD_DMEM);
    assign accept   = rx_valid && loading;
    assign rx_ready = loading;
    assign busy     = loading;
    assign done     = (state_q == DONE);
    assign checksum = checksum_q;

    // The core is released only once DONE is reached and the final dmem
    // write has drained; leaving DONE on start puts it straight back in reset.
    assign core_rst = !((state_q == DONE) && !wrValid_q);

    // State, stream position, checksum and pending-write registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            laneIdx_q  <= 2'd0;
            wordAddr_q <= 9'd0;
            checksum_q <= 8'd0;
            wrValid_q  <= 1'b0;
            wrDmem_q   <= 1'b0;
            wrLane_q   <= 2'd0;
            wrAddr_q   <= 9'd0;
            wrData_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            laneIdx_q  <= laneIdx_d;
            wordAddr_q <= wordAddr_d;
            checksum_q <= checksum_d;
            wrValid_q  <= wrValid_d;
            wrDmem_q   <= wrDmem_d;
            wrLane_q   <= wrLane_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
        end
    end

    // Next-state logic: start arms a fresh load from IDLE/DONE, each accepted
    // byte advances lane/address, and the last word of each memory moves on.
    always_comb begin
        state_d    = state_q;
        laneIdx_d  = laneIdx_q;
        wordAddr_d = wordAddr_q;
        checksum_d = checksum_q;
        wrValid_d  = 1'b0;
        wrDmem_d   = (state_q == LOAD_DMEM);
        wrLane_d   = laneIdx_q;
        wrAddr_d   = wordAddr_q;
        wrData_d   = rx_data;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD_IMEM;
                    laneIdx_d  = 2'd0;
                    wordAddr_d = 9'd0;
                    checksum_d = 8'd0;
                end
            end
            LOAD_IMEM, LOAD_DMEM: begin
                if (accept) begin
                    wrValid_d  = 1'b1;
                    checksum_d = checksum_q + rx_data;
                    if (laneIdx_q == 2'd3) begin
                        laneIdx_d = 2'd0;
                        if (wordAddr_q == LastAddr) begin
                            wordAddr_d = 9'd0;
                            state_d    = (state_q == LOAD_IMEM) ? LOAD_DMEM : DONE;
                        end else begin
                            wordAddr_d = wordAddr_q + 9'd1;
                        end
                    end else begin
                        laneIdx_d = laneIdx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pin decode: every lane idles (disabled, all-ones enables, zero
    // address/data) except the single lane named by the pending write.
    always_comb begin
        CEN_imem  = 4'b1111;
        GWEN_imem = 4'b1111;
        WEN_imem  = {4{8'hFF}};
        A_imem    = '0;
        D_imem    = '0;
        CEN_dmem  = 4'b1111;
        GWEN_dmem = 4'b1111;
        WEN_dmem  = {4{8'hFF}};
        A_dmem    = '0;
        D_dmem    = '0;

        if (wrValid_q) begin
            if (wrDmem_q) begin
                CEN_dmem[wrLane_q]  = 1'b0;
                GWEN_dmem[wrLane_q] = 1'b0;
                WEN_dmem[wrLane_q]  = 8'h00;
                A_dmem[wrLane_q]    = wrAddr_q;
                D_dmem[wrLane_q]    = wrData_q;
            end else begin
                CEN_imem[wrLane_q]  = 1'b0;
                GWEN_imem[wrLane_q] = 1'b0;
                WEN_imem[wrLane_q]  = 8'h00;
                A_imem[wrLane_q]    = wrAddr_q;
                D_imem[wrLane_q]    = wrData_q;
            end
        end
    end

endmodule
